// File: rtl/tiny_rv_opfetch.sv
// Operand fetch / issue stage with a pending-write scoreboard and a registered issue slot.
// Optional writeback-to-operand bypass is enabled by defining TINY_RV_OPF_BYPASS_EN.
module tiny_rv_opfetch (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_we,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [7:0]  i_ctrl,
  output logic        o_ready,
  output logic [4:0]  o_rf_raddr1,
  output logic [4:0]  o_rf_raddr2,
  input  logic [31:0] i_rf_rdata1,
  input  logic [31:0] i_rf_rdata2,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_valid,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [4:0]  o_rd,
  output logic        o_rd_we,
  output logic [31:0] o_pc,
  output logic [31:0] o_imm,
  output logic [7:0]  o_ctrl,
  input  logic        i_ready,
  input  logic        i_flush
);

  logic [31:0] pend_q, pend_d;
  logic        byp1, byp2;
  logic        src1_pend, src2_pend, dst_pend, hazard, accept;
  logic [31:0] op1_d, op2_d;

  assign o_rf_raddr1 = i_rs1;
  assign o_rf_raddr2 = i_rs2;

`ifdef TINY_RV_OPF_BYPASS_EN
  assign byp1 = i_wb_valid && (i_wb_rd == i_rs1) && (i_rs1 != 5'd0);
  assign byp2 = i_wb_valid && (i_wb_rd == i_rs2) && (i_rs2 != 5'd0);
  assign op1_d = byp1 ? i_wb_data : i_rf_rdata1;
  assign op2_d = byp2 ? i_wb_data : i_rf_rdata2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^i_wb_data;
  assign byp1  = 1'b0;
  assign byp2  = 1'b0;
  assign op1_d = i_rf_rdata1;
  assign op2_d = i_rf_rdata2;
`endif

  assign src1_pend = (i_rs1 != 5'd0) && pend_q[i_rs1] && !byp1;
  assign src2_pend = (i_rs2 != 5'd0) && pend_q[i_rs2] && !byp2;
  // Stalling on a pending destination keeps at most one write per register in flight.
  assign dst_pend  = i_rd_we && (i_rd != 5'd0) && pend_q[i_rd] &&
                     !(i_wb_valid && (i_wb_rd == i_rd));
  assign hazard    = src1_pend || src2_pend || dst_pend;

  assign o_ready = !i_rst && (!o_valid || i_ready) && !hazard && !i_flush;
  assign accept  = i_valid && o_ready;

  always_comb begin
    pend_d = pend_q;
    if (i_wb_valid && (i_wb_rd != 5'd0)) pend_d[i_wb_rd] = 1'b0;
    // A killed entry never reaches writeback, so its reservation is dropped here.
    if (i_flush && o_valid && o_rd_we) pend_d[o_rd] = 1'b0;
    if (accept && i_rd_we && (i_rd != 5'd0)) pend_d[i_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q  <= '0;
      o_valid <= 1'b0;
      o_op1   <= '0;
      o_op2   <= '0;
      o_rd    <= '0;
      o_rd_we <= 1'b0;
      o_pc    <= '0;
      o_imm   <= '0;
      o_ctrl  <= '0;
    end else begin
      pend_q <= pend_d;
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (accept) begin
        o_valid <= 1'b1;
        o_op1   <= op1_d;
        o_op2   <= op2_d;
        o_rd    <= i_rd;
        o_rd_we <= i_rd_we;
        o_pc    <= i_pc;
        o_imm   <= i_imm;
        o_ctrl  <= i_ctrl;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tiny_rv_opfetch.sv
// Scoreboard bench for tiny_rv_opfetch: directed vectors push expected issues, a monitor
// pops and compares on every transfer to execute. Expectations follow TINY_RV_OPF_BYPASS_EN.
module tb_tiny_rv_opfetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0;
  logic        i_rd_we = 1'b0;
  logic [31:0] i_pc = '0, i_imm = '0;
  logic [7:0]  i_ctrl = '0;
  logic        o_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        o_valid;
  logic [31:0] o_op1, o_op2, o_pc, o_imm;
  logic [4:0]  o_rd;
  logic        o_rd_we;
  logic [7:0]  o_ctrl;
  logic        i_ready = 1'b1;
  logic        i_flush = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];

  tiny_rv_opfetch dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_rd        (i_rd),
    .i_rd_we     (i_rd_we),
    .i_pc        (i_pc),
    .i_imm       (i_imm),
    .i_ctrl      (i_ctrl),
    .o_ready     (o_ready),
    .o_rf_raddr1 (rf_raddr1),
    .o_rf_raddr2 (rf_raddr2),
    .i_rf_rdata1 (rf_rdata1),
    .i_rf_rdata2 (rf_rdata2),
    .i_wb_valid  (wb_valid),
    .i_wb_rd     (wb_rd),
    .i_wb_data   (wb_data),
    .o_valid     (o_valid),
    .o_op1       (o_op1),
    .o_op2       (o_op2),
    .o_rd        (o_rd),
    .o_rd_we     (o_rd_we),
    .o_pc        (o_pc),
    .o_imm       (o_imm),
    .o_ctrl      (o_ctrl),
    .i_ready     (i_ready),
    .i_flush     (i_flush)
  );

  always #5 clk = ~clk;

  // Register file model: x0 reads 0, reset value 0x100 + index.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer to execute must match the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready && !i_flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got pc %h expected no issue", o_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_op1", o_op1, e.op1);
        chk("issue_op2", o_op2, e.op2);
        chk("issue_pc", o_pc, e.pc);
        chk("issue_imm", o_imm, e.imm);
        chk("issue_ctrl", 32'(o_ctrl), 32'(e.ctrl));
        chk("issue_rd", 32'(o_rd), 32'(e.rd));
        chk("issue_rd_we", 32'(o_rd_we), 32'(e.we));
      end
    end
  end

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic we, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [7:0] ctrl);
    i_valid = 1'b1;
    i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_rd_we = we;
    i_pc = pc; i_imm = imm; i_ctrl = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check o_ready at the negedge, optionally queue the expected issue, advance one cycle.
  task automatic step(input logic exp_rdy, input bit push, input logic [31:0] e1,
                      input logic [31:0] e2);
    exp_t e;
    @(negedge clk);
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    if (push && exp_rdy) begin
      e = '{op1: e1, op2: e2, pc: i_pc, imm: i_imm, ctrl: i_ctrl, rd: i_rd, we: i_rd_we};
      exp_q.push_back(e);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a valid request present so o_ready = 0 is meaningful.
    set_instr(5'd1, 5'd2, 5'd3, 1'b1, 32'h10, 32'h0, 8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    chk("rst_o_op1", o_op1, 32'd0);
    chk("rst_o_pc", o_pc, 32'd0);
    chk("rst_o_ctrl", 32'(o_ctrl), 32'd0);
    chk("rst_pend", dut.pend_q, 32'd0);
    chk("raddr1", 32'(rf_raddr1), 32'd1);
    tick();
    rst = 1'b0;

    // Producer of x5, then a consumer of x5 stalls with no writeback.
    set_instr(5'd1, 5'd2, 5'd5, 1'b1, 32'h100, 32'h0, 8'h01);
    step(1'b1, 1'b1, 32'h101, 32'h102);
    set_instr(5'd5, 5'd0, 5'd6, 1'b1, 32'h104, 32'h4, 8'h02);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("pend5", 32'(dut.pend_q[5]), 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // Writeback of x5 while the consumer waits.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
`ifdef TINY_RV_OPF_BYPASS_EN
    step(1'b1, 1'b1, 32'hDEADBEEF, 32'h0);
    wb_valid = 1'b0;
`else
    step(1'b0, 1'b0, 32'h0, 32'h0);
    wb_valid = 1'b0;
    step(1'b1, 1'b1, 32'hDEADBEEF, 32'h0);
`endif

    // Reader of x0 alongside a writeback to x0; x0 never becomes pending.
    set_instr(5'd0, 5'd3, 5'd0, 1'b1, 32'h108, 32'h0, 8'h03);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    step(1'b1, 1'b1, 32'h0, 32'h103);
    wb_valid = 1'b0;
    chk("pend_after_x0", dut.pend_q, 32'h0000_0040);

    // Back-pressure: A held for 3 cycles, B waits, then back-to-back B and C.
    set_instr(5'd1, 5'd2, 5'd8, 1'b1, 32'h200, 32'h55, 8'h22);
    step(1'b1, 1'b1, 32'h101, 32'h102);
    set_instr(5'd3, 5'd4, 5'd9, 1'b1, 32'h204, 32'h66, 8'h23);
    i_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 32'(o_ready), 32'd0);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_pc", o_pc, 32'h200);
      chk("stall_op1", o_op1, 32'h101);
      chk("stall_rd", 32'(o_rd), 32'd8);
      tick();
      wb_valid = 1'b0;
    end
    i_ready = 1'b1;
    step(1'b1, 1'b1, 32'h103, 32'h104);
    set_instr(5'd0, 5'd0, 5'd0, 1'b0, 32'h208, 32'h0, 8'h24);
    step(1'b1, 1'b1, 32'h0, 32'h0);

    // Writer of x7 flushed while held; x7 reader then issues without stall.
    set_instr(5'd0, 5'd0, 5'd7, 1'b1, 32'h300, 32'h0, 8'h30);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0);
    i_flush = 1'b0; i_ready = 1'b1;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_pend7", 32'(dut.pend_q[7]), 32'd0);
    set_instr(5'd7, 5'd0, 5'd0, 1'b0, 32'h304, 32'h0, 8'h31);
    step(1'b1, 1'b1, 32'h107, 32'h0);

    // Writer of x3 held, reader of x3 stalls, then asynchronous reset mid-cycle.
    set_instr(5'd0, 5'd0, 5'd3, 1'b1, 32'h308, 32'h0, 8'h32);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    i_ready = 1'b0;
    set_instr(5'd3, 5'd0, 5'd0, 1'b0, 32'h30c, 32'h0, 8'h33);
    @(negedge clk);
    chk("stall3_ready", 32'(o_ready), 32'd0);
    chk("pend3", 32'(dut.pend_q[3]), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_pend", dut.pend_q, 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd0);
    chk("arst_pc", o_pc, 32'd0);
    chk("arst_rd", 32'(o_rd), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    tick();
    rst = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
